// File: rtl/adder_result_buffer_pkg.sv
// Shared definitions for the adder stage and the result buffer behind it.
//   ADDER_W   : width of the adder sum
//   RESULT_W  : width of one stored result, {cout, s}
//   result_t  : packed result, carry in the MSB, sum below it
//   OCC_*     : occupancy states derived from the buffer level
//   pack_result() : builds a result_t from the adder outputs
package adder_result_buffer_pkg;

    localparam int ADDER_W  = 4;
    localparam int RESULT_W = ADDER_W + 1;

    typedef struct packed {
        logic               cout;
        logic [ADDER_W-1:0] s;
    } result_t;

    // Occupancy view of the buffer; the level counter is the real state,
    // these codes are only a readable summary of it.
    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

    function automatic result_t pack_result(input logic cout, input logic [ADDER_W-1:0] s);
        result_t r;
        r.cout = cout;
        r.s    = s;
        return r;
    endfunction

endpackage

// File: rtl/adder_result_buffer_if.sv
// Handshake bundle between the adder, the result buffer and its consumer.
//   in_valid/s/cout/in_ready      : upstream adder results into the buffer
//   out_valid/out_ready/out_data  : buffered results towards the consumer
// Handshake rule: a transfer happens on a rising clk edge when valid and
// ready are both high before that edge; valid never waits on ready, and
// ready reflects only the buffer state before the edge.
//   master : the adder/consumer side (drives in_valid, s, cout, out_ready)
//   slave  : the buffer side (drives in_ready, out_valid, out_data)
interface adder_result_buffer_if
    import adder_result_buffer_pkg::*;
#(
    parameter int DW = RESULT_W
);
    logic               in_valid;
    logic [ADDER_W-1:0] s;
    logic               cout;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;

    modport master (
        output in_valid, s, cout, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, s, cout, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/result_fifo_mem.sv
// Storage array for the result buffer: DEPTH x DW, one synchronous write
// port and one asynchronous read port. Contents are not reset; validity
// is tracked by the control logic in the top level.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module result_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int DW    = 5
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/adder_result_buffer.sv
// FIFO that buffers {cout, s} results from the adder for a consumer.
// Results pushed while full are dropped and counted.
//   clk       : sole clock, rising edge
//   reset     : asynchronous, active-low
//   bus       : handshake bundle (slave side)
//   level     : current occupancy, 0..DEPTH
//   drop_cnt  : results lost while full, saturating at 255
//   overflow  : sticky, set on the first drop
//   occ_state : occupancy state (OCC_EMPTY / OCC_PARTIAL / OCC_FULL)
module adder_result_buffer
    import adder_result_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = RESULT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    adder_result_buffer_if.slave     bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt,
    output logic                     overflow,
    output logic [1:0]               occ_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          push;
    logic          pop;
    logic          drop;
    result_t       in_result;

    always_comb begin
        occ_state = OCC_PARTIAL;
        if (level == '0) begin
            occ_state = OCC_EMPTY;
        end else if (level == LW'(DEPTH)) begin
            occ_state = OCC_FULL;
        end
    end

    assign bus.in_ready  = (occ_state != OCC_FULL);
    assign bus.out_valid = (occ_state != OCC_EMPTY);

    // Decisions use the pre-edge state only: a pop on a full buffer does
    // not make room for a push on the same edge.
    assign push = bus.in_valid &  bus.in_ready;
    assign drop = bus.in_valid & ~bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    assign in_result = pack_result(bus.cout, bus.s);
    assign wr_data   = DW'(in_result);

    result_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Storage is not cleared, so mask the head when nothing is held.
    assign bus.out_data = bus.out_valid ? rd_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            // Pointers are AW bits wide and DEPTH is a power of two, so
            // plain increment wraps modulo DEPTH.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_result_buffer.sv
// Self-checking bench for adder_result_buffer (DEPTH=4, DW=5).
module tb_adder_result_buffer;
    localparam int DEPTH = 4;
    localparam int DW    = 5;
    localparam int LW    = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    adder_result_buffer_if #(.DW(DW)) bus ();

    logic [LW-1:0] level;
    logic [7:0]    drop_cnt;
    logic          overflow;
    logic [1:0]    occ_state;

    adder_result_buffer #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .occ_state (occ_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The buffer is a bounded queue; pushes into a full queue are counted.
    logic [DW-1:0] exp_q[$];
    int            m_drops = 0;
    logic          m_ovf   = 1'b0;

    always @(posedge clk or negedge reset) begin : model
        int pre_size;
        if (!reset) begin
            exp_q.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            pre_size = exp_q.size();
            if (pre_size > 0 && bus.out_ready) begin
                void'(exp_q.pop_front());
            end
            if (bus.in_valid) begin
                if (pre_size < DEPTH) begin
                    exp_q.push_back({bus.cout, bus.s});
                end else begin
                    if (m_drops < 255) m_drops++;
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        int n;
        if (reset) begin
            n = exp_q.size();
            chk("level",     32'(level),          32'(n));
            chk("out_valid", 32'(bus.out_valid),  32'(n != 0));
            chk("in_ready",  32'(bus.in_ready),   32'(n != DEPTH));
            chk("out_data",  32'(bus.out_data),   (n != 0) ? 32'(exp_q[0]) : 32'd0);
            chk("drop_cnt",  32'(drop_cnt),       32'(m_drops));
            chk("overflow",  32'(overflow),       32'(m_ovf));
            chk("occ_state", 32'(occ_state),      (n == 0) ? 32'd0 : (n == DEPTH) ? 32'd2 : 32'd1);
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic iv, input logic [3:0] sv, input logic cv, input logic ordy);
        bus.in_valid  = iv;
        bus.s         = sv;
        bus.cout      = cv;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.s         = 4'h0;
        bus.cout      = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    logic [DW-1:0] seq_exp [4];

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level",     32'(level),         32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),      32'd0);
        chk("rst_overflow",  32'(overflow),      32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 3+4+0: single push, visible after the edge
        drive(1'b1, 4'd7, 1'b0, 1'b0);
        chk("first_out_valid", 32'(bus.out_valid), 32'd1);
        chk("first_out_data",  32'(bus.out_data),  32'b00111);
        chk("first_level",     32'(level),         32'd1);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        chk("first_drain_level", 32'(level), 32'd0);

        // fill to full, then drain in order
        drive(1'b1, 4'd3, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 1'b1, 1'b0);
        drive(1'b1, 4'd4, 1'b0, 1'b0);
        drive(1'b1, 4'hF, 1'b1, 1'b0);
        chk("fill_level",    32'(level),        32'd4);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
        seq_exp[0] = 5'b00011;
        seq_exp[1] = 5'b10011;
        seq_exp[2] = 5'b00100;
        seq_exp[3] = 5'b11111;
        for (int i = 0; i < 4; i++) begin
            chk("order_data", 32'(bus.out_data), 32'(seq_exp[i]));
            drive(1'b0, 4'd0, 1'b0, 1'b1);
        end
        chk("order_empty", 32'(bus.out_valid), 32'd0);

        // drops while full
        for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 8), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h1, 1'b1, 1'b0);
        chk("drop3_cnt",   32'(drop_cnt),     32'd3);
        chk("drop3_ovf",   32'(overflow),     32'd1);
        chk("drop3_level", 32'(level),        32'd4);
        chk("drop3_head",  32'(bus.out_data), 32'b01000);
        drive(1'b1, 4'h2, 1'b0, 1'b1);
        chk("drop_pop_cnt",   32'(drop_cnt), 32'd4);
        chk("drop_pop_level", 32'(level),    32'd3);
        repeat (3) drive(1'b0, 4'd0, 1'b0, 1'b1);

        // streaming: one in, one out each cycle across pointer wraps
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'(i), 1'(i % 2), 1'b1);
            chk("stream_level", 32'(level),    32'd1);
            chk("stream_drops", 32'(drop_cnt), 32'd4);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 99) < 70), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 45));
        end

        // asynchronous reset mid-cycle with two entries held
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 4'd0, 1'b0, 1'b1);
        repeat (DEPTH) drive(1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 4'hA, 1'b0, 1'b0);
        drive(1'b1, 4'hB, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(level), 32'd2);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_level",     32'(level),         32'd0);
        chk("async_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("async_rst_out_data",  32'(bus.out_data),  32'd0);
        chk("async_rst_drop_cnt",  32'(drop_cnt),      32'd0);
        chk("async_rst_overflow",  32'(overflow),      32'd0);
        @(negedge clk);
        reset = 1'b1;

        // saturation of the drop counter
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        chk("sat_drop_cnt", 32'(drop_cnt),     32'd255);
        chk("sat_overflow", 32'(overflow),     32'd1);
        chk("sat_level",    32'(level),        32'd4);
        chk("sat_head",     32'(bus.out_data), 32'b00000);
        repeat (DEPTH) drive(1'b0, 4'd0, 1'b0, 1'b1);
        chk("sat_drained", 32'(bus.out_valid), 32'd0);

        idle_inputs();
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
